// File: rtl/dram_access_ctrl.sv
// Open-row DRAM request controller with tRCD/tRP timing and periodic refresh.
// Optional row hit/miss statistics are enabled by defining DRAM_ROW_STATS_EN.
module dram_access_ctrl #(
    parameter int T_RCD            = 2,
    parameter int T_RP             = 2,
    parameter int T_RFC            = 4,
    parameter int REFRESH_INTERVAL = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [7:0]  req_addr,
    input  logic [7:0]  req_wdata,
    output logic        resp_valid,
    output logic [7:0]  resp_rdata,
    output logic [7:0]  mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_write_en,
    input  logic [7:0]  mem_rdata,
    output logic        row_open
`ifdef DRAM_ROW_STATS_EN
    ,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        PRECHARGE,
        ACTIVATE,
        ACCESS,
        READ_WAIT,
        REFRESH
    } state_t;

    state_t      state, state_nx;
    logic [3:0]  timer, timer_nx;
    logic        row_open_nx;
    logic [3:0]  open_row, open_row_nx;
    logic        pre_ref, pre_ref_nx;
    logic        cap_we;
    logic [7:0]  cap_addr, cap_wdata;
    logic [15:0] ref_cnt;
    logic        ref_pend;
    logic        ref_done;
    logic        ref_wrap;
    logic        accept;
    logic        hit;

    assign req_ready    = (state == IDLE) && !ref_pend;
    assign accept       = req_valid && req_ready;
    assign hit          = row_open && (open_row == req_addr[7:4]);
    assign ref_wrap     = (ref_cnt == 16'(REFRESH_INTERVAL - 1));
    assign mem_addr     = cap_addr;
    assign mem_wdata    = cap_wdata;
    assign mem_write_en = (state == ACCESS) && cap_we;

    always_comb begin
        state_nx    = state;
        timer_nx    = timer;
        row_open_nx = row_open;
        open_row_nx = open_row;
        pre_ref_nx  = pre_ref;
        ref_done    = 1'b0;
        unique case (state)
            IDLE: begin
                // Refresh has priority over a waiting request
                if (ref_pend) begin
                    if (row_open) begin
                        state_nx   = PRECHARGE;
                        timer_nx   = 4'(T_RP - 1);
                        pre_ref_nx = 1'b1;
                    end else begin
                        state_nx = REFRESH;
                        timer_nx = 4'(T_RFC - 1);
                    end
                end else if (accept) begin
                    if (hit) begin
                        state_nx = ACCESS;
                    end else if (row_open) begin
                        state_nx   = PRECHARGE;
                        timer_nx   = 4'(T_RP - 1);
                        pre_ref_nx = 1'b0;
                    end else begin
                        state_nx = ACTIVATE;
                        timer_nx = 4'(T_RCD - 1);
                    end
                end
            end
            PRECHARGE: begin
                if (timer == 4'd0) begin
                    row_open_nx = 1'b0;
                    if (pre_ref) begin
                        state_nx = REFRESH;
                        timer_nx = 4'(T_RFC - 1);
                    end else begin
                        state_nx = ACTIVATE;
                        timer_nx = 4'(T_RCD - 1);
                    end
                end else begin
                    timer_nx = timer - 4'd1;
                end
            end
            ACTIVATE: begin
                if (timer == 4'd0) begin
                    state_nx    = ACCESS;
                    row_open_nx = 1'b1;
                    open_row_nx = cap_addr[7:4];
                end else begin
                    timer_nx = timer - 4'd1;
                end
            end
            ACCESS: begin
                state_nx = cap_we ? IDLE : READ_WAIT;
            end
            READ_WAIT: begin
                state_nx = IDLE;
            end
            REFRESH: begin
                if (timer == 4'd0) begin
                    state_nx = IDLE;
                    ref_done = 1'b1;
                end else begin
                    timer_nx = timer - 4'd1;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            timer      <= 4'd0;
            row_open   <= 1'b0;
            open_row   <= 4'd0;
            pre_ref    <= 1'b0;
            cap_we     <= 1'b0;
            cap_addr   <= 8'd0;
            cap_wdata  <= 8'd0;
            resp_valid <= 1'b0;
            resp_rdata <= 8'd0;
        end else begin
            state      <= state_nx;
            timer      <= timer_nx;
            row_open   <= row_open_nx;
            open_row   <= open_row_nx;
            pre_ref    <= pre_ref_nx;
            resp_valid <= (state == READ_WAIT);
            if (state == READ_WAIT) begin
                resp_rdata <= mem_rdata;
            end
            if (accept) begin
                cap_we    <= req_we;
                cap_addr  <= req_addr;
                cap_wdata <= req_wdata;
            end
        end
    end

    // An expiry coinciding with the end of a refresh is absorbed by it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt  <= 16'd0;
            ref_pend <= 1'b0;
        end else begin
            ref_cnt <= ref_wrap ? 16'd0 : ref_cnt + 16'd1;
            if (ref_done) begin
                ref_pend <= 1'b0;
            end else if (ref_wrap) begin
                ref_pend <= 1'b1;
            end
        end
    end

`ifdef DRAM_ROW_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count  <= 16'd0;
            miss_count <= 16'd0;
        end else if (accept) begin
            if (hit) begin
                if (hit_count != 16'hFFFF) begin
                    hit_count <= hit_count + 16'd1;
                end
            end else if (miss_count != 16'hFFFF) begin
                miss_count <= miss_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dram_access_ctrl.sv
// Bench for dram_access_ctrl: timing/data model built from latency rules,
// directed test-plan scenarios plus randomized traffic.
module tb_dram_access_ctrl;

    localparam int TRCD = 2;
    localparam int TRP  = 2;
    localparam int TRFC = 4;
    localparam int RINT = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_we;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       resp_valid;
    logic [7:0] resp_rdata;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_write_en;
    logic [7:0] mem_rdata;
    logic       row_open;
`ifdef DRAM_ROW_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
    int          m_hit;
    int          m_miss;
`endif

    always #5 clk = ~clk;

    dram_access_ctrl #(
        .T_RCD(TRCD),
        .T_RP(TRP),
        .T_RFC(TRFC),
        .REFRESH_INTERVAL(RINT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we(req_we),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid),
        .resp_rdata(resp_rdata),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_write_en(mem_write_en),
        .mem_rdata(mem_rdata),
        .row_open(row_open)
`ifdef DRAM_ROW_STATS_EN
        ,
        .hit_count(hit_count),
        .miss_count(miss_count)
`endif
    );

    // DRAM array environment: synchronous write, registered read
    logic [7:0] arr [256];
    always @(posedge clk) begin
        if (mem_write_en) arr[mem_addr] <= mem_wdata;
        mem_rdata <= arr[mem_addr];
    end

    int         total = 0;
    int         bad   = 0;
    int         now, idle_at, ref_end, acc_edge, resp_edge, acc_at;
    int         resp_seen;
    logic [7:0] resp_data;
    bit         pend, m_open, cur_we, last_acc;
    logic [3:0] m_row;
    logic [7:0] cur_addr, cur_wd, exp_rd;
    logic [7:0] exp_mem [256];
    int         busy;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)",
                     name, act, exp, now);
        end
    endtask

    task automatic model_reset();
        now = 0; idle_at = 0; ref_end = -1;
        acc_edge = -1; resp_edge = -1; acc_at = -1;
        resp_seen = -1; pend = 0; m_open = 0; cur_we = 0;
        m_row = 0;
`ifdef DRAM_ROW_STATS_EN
        m_hit = 0; m_miss = 0;
`endif
    endtask

    // Decide the next edge from the model, clock once, then compare
    task automatic tick();
        int pre, act;
        bit h;
        last_acc = 0;
        if (now >= idle_at) begin
            if (pend) begin
                ref_end = now + 1 + (m_open ? TRP : 0) + TRFC;
                idle_at = ref_end;
                m_open  = 0;
            end else if (req_valid) begin
                h   = m_open && (m_row == req_addr[7:4]);
                pre = (m_open && !h) ? TRP : 0;
                act = h ? 0 : TRCD;
`ifdef DRAM_ROW_STATS_EN
                if (h) m_hit = (m_hit == 65535) ? m_hit : m_hit + 1;
                else m_miss = (m_miss == 65535) ? m_miss : m_miss + 1;
`endif
                acc_at   = now + 1;
                acc_edge = acc_at + pre + act;
                cur_we   = req_we;
                cur_addr = req_addr;
                cur_wd   = req_wdata;
                if (req_we) begin
                    exp_mem[req_addr] = req_wdata;
                    idle_at = acc_edge + 1;
                end else begin
                    exp_rd    = exp_mem[req_addr];
                    resp_edge = acc_edge + 2;
                    idle_at   = resp_edge;
                end
                m_open   = 1;
                m_row    = req_addr[7:4];
                last_acc = 1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        now++;
        if (now == ref_end) pend = 0;
        else if (now % RINT == 0) pend = 1;
        chk("req_ready", req_ready, (now >= idle_at) && !pend);
        chk("resp_valid", resp_valid, now == resp_edge);
        if (now == resp_edge) chk("resp_rdata", resp_rdata, exp_rd);
        if (resp_valid) begin
            resp_seen = now;
            resp_data = resp_rdata;
        end
        chk("mem_write_en", mem_write_en, (now == acc_edge) && cur_we);
        if (now == acc_edge) begin
            chk("mem_addr", mem_addr, cur_addr);
            if (cur_we) chk("mem_wdata", mem_wdata, cur_wd);
        end
        if (now >= idle_at) chk("row_open", row_open, m_open);
`ifdef DRAM_ROW_STATS_EN
        chk("hit_count", hit_count, m_hit);
        chk("miss_count", miss_count, m_miss);
`endif
    endtask

    task automatic send(input bit we, input logic [7:0] a,
                        input logic [7:0] d);
        int n;
        req_valid = 1; req_we = we; req_addr = a; req_wdata = d;
        n = 0;
        do begin
            tick();
            n++;
        end while (!last_acc && n < 200);
        if (!last_acc) chk("accept_timeout", 0, 1);
        req_valid = 0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (now < idle_at && n < 200) begin
            tick();
            n++;
        end
        if (now < idle_at) chk("idle_timeout", 0, 1);
    endtask

    task automatic ready_gap();
        int n;
        busy = 0;
        n = 0;
        do begin
            tick();
            n++;
            if (!req_ready) busy++;
        end while (!req_ready && n < 100);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            arr[i] = 8'd0;
            exp_mem[i] = 8'd0;
        end
        model_reset();
        rst_n = 0; req_valid = 0; req_we = 0;
        req_addr = 0; req_wdata = 0;
        repeat (3) @(negedge clk);
        chk("rst_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_row_open", row_open, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_we", mem_write_en, 0);
        rst_n = 1;
        model_reset();

        // Cold write, miss write, hit read, miss read
        send(1, 8'h71, 8'hC3);
        wait_idle();
        send(1, 8'h23, 8'h5A);
        wait_idle();
        send(0, 8'h23, 8'h00);
        wait_idle();
        chk("hit_latency", resp_seen - acc_at, 2);
        chk("hit_data", resp_data, 8'h5A);
        send(0, 8'h71, 8'h00);
        wait_idle();
        chk("miss_latency", resp_seen - acc_at, 6);
        chk("miss_data", resp_data, 8'hC3);
        chk("open_row_7", row_open, 1);

        // Refresh with row open, request held during the window
        req_valid = 1; req_we = 1; req_addr = 8'h30; req_wdata = 8'h10;
        ready_gap();
        chk("refresh_gap", busy, TRP + TRFC);
        chk("refresh_row_closed", row_open, 0);
        send(1, 8'h30, 8'h10);
        wait_idle();

        // Row hit stream
        for (int i = 1; i < 4; i++) begin
            send(1, 8'h30 + 8'(i), 8'h10 + 8'(i));
            wait_idle();
        end
        for (int i = 0; i < 4; i++) begin
            send(0, 8'h30 + 8'(i), 8'h00);
            wait_idle();
            chk("stream_data", resp_data, 8'h10 + 8'(i));
        end

        // Async reset in the middle of ACTIVATE
        send(0, 8'h50, 8'h00);
        while (now < acc_edge - TRCD + 1) tick();
        #2 rst_n = 0;
        #1;
        chk("arst_mem_addr", mem_addr, 0);
        chk("arst_row_open", row_open, 0);
        chk("arst_resp_valid", resp_valid, 0);
        chk("arst_mem_we", mem_write_en, 0);
        @(negedge clk);
        rst_n = 1;
        model_reset();

        // Refresh expiry during ACTIVATE of a read
        while (now < 14) tick();
        send(0, 8'h71, 8'h00);
        wait_idle();
        chk("collide_latency", resp_seen - acc_at, 2 + TRCD);
        chk("collide_data", resp_data, 8'hC3);
        ready_gap();
        chk("collide_gap", busy, TRP + TRFC);
        send(0, 8'h23, 8'h00);
        wait_idle();
        chk("after_ref_data", resp_data, 8'h5A);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            req_valid = 1'($urandom);
            req_we    = 1'($urandom);
            req_addr  = {4'($urandom_range(0, 3)), 4'($urandom)};
            req_wdata = 8'($urandom);
            tick();
        end
        req_valid = 0;
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
